// File: rtl/mac_pkg.sv
// mac_pkg
// Shared types for the Rx-domain frame buffer:
//   - wr_state_t : write-side framing state (IDLE, FRAME, DISCARD)
//   - entry_t    : one buffer word {tlast, tkeep, tdata}, 37 bits
package mac_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int DATA_NBYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_FRAME   = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic                   tlast;
        logic [DATA_NBYTES-1:0] tkeep;
        logic [DATA_WIDTH-1:0]  tdata;
    } entry_t;

endpackage

// File: rtl/sdp_ram.sv
// sdp_ram
// Simple dual-port RAM: one write port, one read port with a registered
// output. The read register only loads when i_rd_en is high, so it holds
// its word while the downstream stage is stalled. The array is not reset.
// Ports:
//   i_clk                      clock
//   i_wr_en/i_wr_addr/i_wr_data write port
//   i_rd_en/i_rd_addr          read request
//   o_rd_data                  registered read data (valid the cycle after i_rd_en)
module sdp_ram #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rx_packet_fifo.sv
// rx_packet_fifo
// Store-and-forward frame buffer for the 10G MAC Rx path. Whole frames are
// written into an sdp_ram and only become visible to the reader once a clean
// tlast commits them. Bad frames (tuser on tlast) and frames that hit a full
// buffer are rewound atomically, so no fragment ever reaches the output.
// Optional build macro: RX_PACKET_FIFO_STATS_EN enables the frame counters;
// without it o_good_count/o_drop_count are tied to 0.
// Ports:
//   i_clk, i_reset            Rx clock, synchronous active-high reset
//   s00_axis_*                input stream from the MAC (no tready)
//   m00_axis_*                output stream, backpressured by m00_axis_tready
//   o_drop_bad, o_drop_ovf    one-cycle drop pulses
//   o_good_count, o_drop_count committed / dropped frame counters
module rx_packet_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [DATA_WIDTH-1:0]  s00_axis_tdata,
    input  logic [DATA_NBYTES-1:0] s00_axis_tkeep,
    input  logic                   s00_axis_tvalid,
    input  logic                   s00_axis_tlast,
    input  logic                   s00_axis_tuser,
    output logic [DATA_WIDTH-1:0]  m00_axis_tdata,
    output logic [DATA_NBYTES-1:0] m00_axis_tkeep,
    output logic                   m00_axis_tvalid,
    input  logic                   m00_axis_tready,
    output logic                   m00_axis_tlast,
    output logic                   o_drop_bad,
    output logic                   o_drop_ovf,
    output logic [31:0]            o_good_count,
    output logic [31:0]            o_drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_OCC = PW'(DEPTH);

    wr_state_t     r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_commit_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_drop_bad;
    logic          r_drop_ovf;

    logic          r_ram_vld;
    logic          r_out_vld;
    entry_t        r_out;

    logic          w_full;
    logic          w_in_frame;
    logic          w_ovf;
    logic          w_bad;
    logic          w_wr_en;
    logic          w_commit;
    logic          w_out_load;
    logic          w_rd_en;
    entry_t        w_wr_entry;
    entry_t        w_ram_q;

    // Full uses the pre-edge rd_ptr, so a read on the same edge does not
    // make room for the word being written.
    assign w_full     = (r_wr_ptr - r_rd_ptr) == FULL_OCC;
    assign w_in_frame = s00_axis_tvalid && (r_state != WR_DISCARD);
    // A full buffer takes precedence: the frame is lost to overflow whatever
    // its tuser says.
    assign w_ovf      = w_in_frame && w_full;
    assign w_bad      = w_in_frame && !w_full && s00_axis_tlast && s00_axis_tuser;
    assign w_wr_en    = w_in_frame && !w_full && !(s00_axis_tlast && s00_axis_tuser);
    assign w_commit   = w_wr_en && s00_axis_tlast;

    assign w_wr_entry = '{tlast: s00_axis_tlast, tkeep: s00_axis_tkeep, tdata: s00_axis_tdata};

    // Write-side framing FSM with registered drop pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= WR_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_drop_bad   <= 1'b0;
            r_drop_ovf   <= 1'b0;
        end else begin
            r_drop_bad <= w_bad;
            r_drop_ovf <= w_ovf;
            if (w_ovf) begin
                r_wr_ptr <= r_commit_ptr;
                r_state  <= s00_axis_tlast ? WR_IDLE : WR_DISCARD;
            end else if (w_bad) begin
                r_wr_ptr <= r_commit_ptr;
                r_state  <= WR_IDLE;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (s00_axis_tlast) begin
                    r_commit_ptr <= r_wr_ptr + 1'b1;
                    r_state      <= WR_IDLE;
                end else begin
                    r_state <= WR_FRAME;
                end
            end else if (s00_axis_tvalid && s00_axis_tlast && (r_state == WR_DISCARD)) begin
                r_state <= WR_IDLE;
            end
        end
    end

    // Read side: RAM output register (r_ram_vld) feeds the AXIS output
    // register (r_out_vld). Output handshake: a word transfers on an edge
    // where m00_axis_tvalid && m00_axis_tready; while tvalid is high and
    // tready low, tvalid/tdata/tkeep/tlast stay unchanged.
    assign w_out_load = r_ram_vld && (!r_out_vld || m00_axis_tready);
    assign w_rd_en    = (r_rd_ptr != r_commit_ptr) && (!r_ram_vld || w_out_load);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_ptr  <= '0;
            r_ram_vld <= 1'b0;
            r_out_vld <= 1'b0;
            r_out     <= '0;
        end else begin
            if (w_rd_en) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_ram_vld <= 1'b1;
            end else if (w_out_load) begin
                r_ram_vld <= 1'b0;
            end
            if (w_out_load) begin
                r_out     <= w_ram_q;
                r_out_vld <= 1'b1;
            end else if (m00_axis_tready) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    sdp_ram #(
        .WIDTH($bits(entry_t)),
        .DEPTH(DEPTH)
    ) u_ram (
        .i_clk    (i_clk),
        .i_wr_en  (w_wr_en),
        .i_wr_addr(r_wr_ptr[AW-1:0]),
        .i_wr_data(w_wr_entry),
        .i_rd_en  (w_rd_en),
        .i_rd_addr(r_rd_ptr[AW-1:0]),
        .o_rd_data(w_ram_q)
    );

    assign m00_axis_tdata  = r_out.tdata;
    assign m00_axis_tkeep  = r_out.tkeep;
    assign m00_axis_tlast  = r_out.tlast;
    assign m00_axis_tvalid = r_out_vld;
    assign o_drop_bad      = r_drop_bad;
    assign o_drop_ovf      = r_drop_ovf;

`ifdef RX_PACKET_FIFO_STATS_EN
    logic [31:0] r_good_count;
    logic [31:0] r_drop_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_good_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_commit) begin
                r_good_count <= r_good_count + 32'd1;
            end
            if (w_bad || w_ovf) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

    assign o_good_count = r_good_count;
    assign o_drop_count = r_drop_count;
`else
    assign o_good_count = 32'd0;
    assign o_drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_rx_packet_fifo.sv
// tb_rx_packet_fifo
// Two instances: u_dut_a (DEPTH=512) for throughput, ordering, bad-frame and
// reset cases; u_dut_b (DEPTH=16) for overflow cases. Inputs are shared and
// d_sel steers tvalid to one instance. Expected output words come from the
// frames the bench itself generated, queued only when the frame must commit.
module tb_rx_packet_fifo;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // shared input drive
    logic [31:0] d_tdata = '0;
    logic [3:0]  d_tkeep = '0;
    logic        d_tlast = 1'b0;
    logic        d_tuser = 1'b0;
    logic        d_tvalid = 1'b0;
    int          d_sel = 0;
    logic        v_a, v_b;
    assign v_a = d_tvalid && (d_sel == 0);
    assign v_b = d_tvalid && (d_sel == 1);

    // tready: mode 0 low, 1 high, 2 random each cycle
    int   mode_a = 1, mode_b = 0;
    logic rnd_a = 1'b0, rnd_b = 1'b0;
    logic tready_a, tready_b;
    assign tready_a = (mode_a == 2) ? rnd_a : (mode_a == 1);
    assign tready_b = (mode_b == 2) ? rnd_b : (mode_b == 1);
    always @(posedge i_clk) begin
        #1;
        rnd_a = 1'($urandom_range(0, 1));
        rnd_b = 1'($urandom_range(0, 1));
    end

    logic [31:0] td_a, td_b, gc_a, gc_b, dc_a, dc_b;
    logic [3:0]  tk_a, tk_b;
    logic        tv_a, tv_b, tl_a, tl_b, db_a, db_b, do_a, do_b;

    rx_packet_fifo #(.DEPTH(512)) u_dut_a (
        .i_clk(i_clk), .i_reset(i_reset),
        .s00_axis_tdata(d_tdata), .s00_axis_tkeep(d_tkeep), .s00_axis_tvalid(v_a),
        .s00_axis_tlast(d_tlast), .s00_axis_tuser(d_tuser),
        .m00_axis_tdata(td_a), .m00_axis_tkeep(tk_a), .m00_axis_tvalid(tv_a),
        .m00_axis_tready(tready_a), .m00_axis_tlast(tl_a),
        .o_drop_bad(db_a), .o_drop_ovf(do_a), .o_good_count(gc_a), .o_drop_count(dc_a)
    );

    rx_packet_fifo #(.DEPTH(16)) u_dut_b (
        .i_clk(i_clk), .i_reset(i_reset),
        .s00_axis_tdata(d_tdata), .s00_axis_tkeep(d_tkeep), .s00_axis_tvalid(v_b),
        .s00_axis_tlast(d_tlast), .s00_axis_tuser(d_tuser),
        .m00_axis_tdata(td_b), .m00_axis_tkeep(tk_b), .m00_axis_tvalid(tv_b),
        .m00_axis_tready(tready_b), .m00_axis_tlast(tl_b),
        .o_drop_bad(db_b), .o_drop_ovf(do_b), .o_good_count(gc_b), .o_drop_count(dc_b)
    );

    // scoreboard
    logic [36:0] exp_q_a[$];
    logic [36:0] exp_q_b[$];
    int n_checks = 0;
    int n_fail = 0;
    int exp_good[2] = '{0, 0};
    int exp_drop[2] = '{0, 0};
    int exp_bad[2]  = '{0, 0};
    int exp_ovf[2]  = '{0, 0};
    int n_bad[2]    = '{0, 0};
    int n_ovf[2]    = '{0, 0};
    bit          prev_stall[2] = '{1'b0, 1'b0};
    logic [36:0] prev_word[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef RX_PACKET_FIFO_STATS_EN
        return 32'(v);
`else
        return 32'(v) & 32'h0;
`endif
    endfunction

    task automatic mon(input int inst, input logic vld, input logic rdy, input logic [36:0] word,
                       input logic bad, input logic ovf);
        logic [36:0] e;
        bit          have;
        if (i_reset) begin
            prev_stall[inst] = 1'b0;
        end else begin
            n_bad[inst] += int'(bad);
            n_ovf[inst] += int'(ovf);
            if (prev_stall[inst])
                check($sformatf("hold_%0d", inst), {25'd0, vld, word}, {25'd0, 1'b1, prev_word[inst]});
            if (vld && rdy) begin
                have = 1'b0;
                e = '0;
                if (inst == 0) begin
                    if (exp_q_a.size() > 0) begin have = 1'b1; e = exp_q_a.pop_front(); end
                end else begin
                    if (exp_q_b.size() > 0) begin have = 1'b1; e = exp_q_b.pop_front(); end
                end
                if (!have) check($sformatf("unexpected_out_%0d", inst), {26'd1, word}, 64'd0);
                else       check($sformatf("out_word_%0d", inst), {27'd0, word}, {27'd0, e});
            end
            prev_stall[inst] = vld && !rdy;
            prev_word[inst]  = word;
        end
    endtask

    always @(negedge i_clk) begin
        mon(0, tv_a, tready_a, {tl_a, tk_a, td_a}, db_a, do_a);
        mon(1, tv_b, tready_b, {tl_b, tk_b, td_b}, db_b, do_b);
    end

    // driver: one word per call, sampled at the next rising edge
    task automatic drive_word(input int sel, input logic [3:0] keep, input logic last, input logic user);
        d_sel    = sel;
        d_tvalid = 1'b1;
        d_tdata  = $urandom;
        d_tkeep  = keep;
        d_tlast  = last;
        d_tuser  = user;
        @(posedge i_clk);
        #1;
    endtask

    // outcome: 0 commit, 1 drop for tuser, 2 drop for overflow
    task automatic send_frame(input int sel, input int len, input bit bad, input logic [3:0] last_keep,
                              input int outcome);
        logic [36:0] words[$];
        for (int i = 0; i < len; i++) begin
            if (i == len - 1) drive_word(sel, last_keep, 1'b1, bad);
            else              drive_word(sel, 4'hF, 1'b0, 1'($urandom_range(0, 1)));
            words.push_back({d_tlast, d_tkeep, d_tdata});
        end
        d_tvalid = 1'b0;
        d_tlast  = 1'b0;
        d_tuser  = 1'b0;
        if (outcome == 0) begin
            exp_good[sel]++;
            foreach (words[k]) begin
                if (sel == 0) exp_q_a.push_back(words[k]);
                else          exp_q_b.push_back(words[k]);
            end
        end else begin
            exp_drop[sel]++;
            if (outcome == 1) exp_bad[sel]++;
            else              exp_ovf[sel]++;
        end
    endtask

    task automatic wait_drain(input int sel, input int budget);
        int left;
        left = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge i_clk);
            left = (sel == 0) ? exp_q_a.size() : exp_q_b.size();
            if (left == 0 && ((sel == 0) ? !tv_a : !tv_b)) break;
        end
        check($sformatf("drain_%0d", sel), 64'(left), 64'd0);
    endtask

    task automatic check_stats(input int sel, input string tag);
        repeat (2) @(negedge i_clk);
        check({tag, "_bad_pulses"}, 64'(n_bad[sel]), 64'(exp_bad[sel]));
        check({tag, "_ovf_pulses"}, 64'(n_ovf[sel]), 64'(exp_ovf[sel]));
        check({tag, "_good_count"}, 64'((sel == 0) ? gc_a : gc_b), 64'(exp_cnt(exp_good[sel])));
        check({tag, "_drop_count"}, 64'((sel == 0) ? dc_a : dc_b), 64'(exp_cnt(exp_drop[sel])));
    endtask

    typedef struct {
        int         sel;
        int         len;
        bit         bad;
        logic [3:0] last_keep;
        int         outcome;
        int         exp_lat;
    } vec_t;

    vec_t vecs[5];
    int   lens[4] = '{1, 2, 17, 375};

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int last_edge;
        int lat;
        int rlen;
        bit rbad;

        vecs[0] = '{sel: 0, len: 16, bad: 1'b0, last_keep: 4'hF, outcome: 0, exp_lat: 2};
        vecs[1] = '{sel: 0, len: 5,  bad: 1'b1, last_keep: 4'hF, outcome: 1, exp_lat: 0};
        vecs[2] = '{sel: 0, len: 1,  bad: 1'b0, last_keep: 4'h1, outcome: 0, exp_lat: 2};
        vecs[3] = '{sel: 1, len: 20, bad: 1'b0, last_keep: 4'hF, outcome: 2, exp_lat: 0};
        vecs[4] = '{sel: 1, len: 8,  bad: 1'b0, last_keep: 4'h3, outcome: 0, exp_lat: 0};

        // reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_axis_a", {27'd0, tv_a, tl_a, tk_a, td_a}, 64'd0);
        check("reset_misc_a", {db_a, do_a, gc_a, dc_a}, 66'd0);
        check("reset_axis_b", {27'd0, tv_b, tl_b, tk_b, td_b}, 64'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;

        // table: good frame, bad frame, 1-word frame, overflow, post-overflow frame
        mode_a = 1;
        mode_b = 0;
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].sel, vecs[v].len, vecs[v].bad, vecs[v].last_keep, vecs[v].outcome);
            last_edge = cyc;
            if (vecs[v].sel == 0) begin
                if (vecs[v].outcome == 0) begin
                    lat = -1;
                    for (int k = 0; k < 8; k++) begin
                        @(negedge i_clk);
                        if (tv_a) begin lat = cyc - last_edge; break; end
                    end
                    check($sformatf("latency_v%0d", v), 64'(lat), 64'(vecs[v].exp_lat));
                end
                wait_drain(0, 100);
            end
            check_stats(vecs[v].sel, $sformatf("vec%0d", v));
        end
        // consumer on instance b wakes up; only the 8-word frame may appear
        @(posedge i_clk);
        #1;
        mode_b = 1;
        wait_drain(1, 100);

        // random backpressure, back-to-back good frames
        mode_a = 2;
        foreach (lens[i]) send_frame(0, lens[i], 1'b0, 4'(1 << $urandom_range(0, 3)), 0);
        wait_drain(0, 4000);
        check_stats(0, "rand_fixed");

        // random frames with random bad flags and idle gaps
        for (int f = 0; f < 10; f++) begin
            rlen = $urandom_range(1, 20);
            rbad = ($urandom_range(0, 3) == 0);
            send_frame(0, rlen, rbad, 4'hF, rbad ? 1 : 0);
            repeat ($urandom_range(0, 2)) @(posedge i_clk);
            #1;
        end
        wait_drain(0, 2000);
        check_stats(0, "rand_mix");

        // exactly full after a good tlast, read on the same edge as next word
        @(posedge i_clk);
        #1;
        mode_b = 0;
        send_frame(1, 2, 1'b0, 4'hF, 0);
        repeat (4) @(posedge i_clk);
        #1;
        send_frame(1, 16, 1'b0, 4'hF, 0);
        mode_b = 1;
        send_frame(1, 3, 1'b0, 4'hF, 2);
        send_frame(1, 10, 1'b0, 4'h7, 0);
        wait_drain(1, 200);
        check_stats(1, "exact_full");

        // reset mid-frame with two committed frames unread
        mode_a = 0;
        send_frame(0, 3, 1'b0, 4'hF, 0);
        send_frame(0, 4, 1'b0, 4'hF, 0);
        for (int i = 0; i < 5; i++) drive_word(0, 4'hF, 1'b0, 1'b0);
        d_tvalid = 1'b0;
        i_reset  = 1'b1;
        exp_q_a.delete();
        exp_q_b.delete();
        exp_good = '{0, 0};
        exp_drop = '{0, 0};
        @(posedge i_clk);
        @(negedge i_clk);
        check("rst_during_axis", {27'd0, tv_a, tl_a, tk_a, td_a}, 64'd0);
        check("rst_during_misc", {db_a, do_a, gc_a, dc_a}, 66'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_after_axis", {27'd0, tv_a, tl_a, tk_a, td_a}, 64'd0);
        check("rst_after_misc", {db_a, do_a, gc_a, dc_a}, 66'd0);
        mode_a = 1;
        repeat (20) @(negedge i_clk);
        check("rst_no_old_data", 64'(tv_a), 64'd0);
        @(posedge i_clk);
        #1;
        send_frame(0, 6, 1'b0, 4'hF, 0);
        wait_drain(0, 100);
        check_stats(0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
